// File: rtl/keccak_padder_pkg.sv
// -----------------------------------------------------------------------------
// keccak_padder_pkg
// Shared constants, types and helpers for the Keccak message padder.
//   - rate/word geometry (1024-bit block built from sixteen 64-bit words)
//   - pad10*1 marker bytes
//   - padder FSM state encoding
//   - clamp_nbytes(): limits a final-word byte count to the word width
// -----------------------------------------------------------------------------
package keccak_padder_pkg;

    localparam int RATE_BITS       = 1024;
    localparam int WORD_BITS       = 64;
    localparam int RATE_BYTES      = RATE_BITS / 8;
    localparam int WORD_BYTES      = WORD_BITS / 8;
    localparam int WORDS_PER_BLOCK = RATE_BITS / WORD_BITS;

    localparam logic [7:0] PAD_FIRST = 8'h01;
    localparam logic [7:0] PAD_LAST  = 8'h80;

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        SEND     = 2'd1,
        SEND_PAD = 2'd2
    } padder_state_t;

    // A final word can never hold more than WORD_BYTES bytes; larger counts
    // are treated as a full word.
    function automatic logic [3:0] clamp_nbytes(input logic [3:0] nbytes);
        return (nbytes > 4'(WORD_BYTES)) ? 4'(WORD_BYTES) : nbytes;
    endfunction

endpackage

// File: rtl/keccak_padder_if.sv
// -----------------------------------------------------------------------------
// keccak_padder_if
// Bundles the two streams around the padder:
//   msg_*  : 64-bit message word stream into the padder (valid/ready)
//   blk_*  : 1024-bit rate block stream out to the hasher (valid/ready)
// Modports:
//   slave  : the padder view (consumes msg_*, produces blk_*)
//   master : the environment view (produces msg_*, consumes blk_*)
// -----------------------------------------------------------------------------
interface keccak_padder_if;
    import keccak_padder_pkg::*;

    logic [WORD_BITS-1:0] msg_data;
    logic                 msg_valid;
    logic                 msg_last;
    logic [3:0]           msg_nbytes;
    logic                 msg_ready;

    logic [RATE_BITS-1:0] blk_data;
    logic                 blk_valid;
    logic                 blk_last;
    logic                 blk_ready;

    modport slave (
        input  msg_data, msg_valid, msg_last, msg_nbytes, blk_ready,
        output msg_ready, blk_data, blk_valid, blk_last
    );

    modport master (
        output msg_data, msg_valid, msg_last, msg_nbytes, blk_ready,
        input  msg_ready, blk_data, blk_valid, blk_last
    );

endinterface

// File: rtl/keccak_padder_pad_word.sv
// -----------------------------------------------------------------------------
// keccak_pad_word
// Combinational per-word padding helper.
//   word_i        : raw 64-bit word (byte i = bits [8i+7:8i])
//   nbytes_i      : number of message bytes kept, 0..8; byte nbytes_i gets
//                   the 0x01 pad marker when it falls inside the word
//   is_top_word_i : word is the last word of the rate block, so byte 7 gets
//                   the 0x80 closing marker
//   word_o        : masked word with the markers ORed in
// -----------------------------------------------------------------------------
module keccak_pad_word
    import keccak_padder_pkg::*;
(
    input  logic [WORD_BITS-1:0] word_i,
    input  logic [3:0]           nbytes_i,
    input  logic                 is_top_word_i,
    output logic [WORD_BITS-1:0] word_o
);

    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_byte
        localparam logic [3:0] IDX    = 4'(gi);
        localparam bit         IS_MSB = (gi == WORD_BYTES - 1);

        logic [7:0] keep_byte;
        logic [7:0] first_byte;
        logic [7:0] last_byte;

        assign keep_byte  = (IDX < nbytes_i) ? word_i[8*gi +: 8] : 8'h00;
        assign first_byte = (IDX == nbytes_i) ? PAD_FIRST : 8'h00;
        assign last_byte  = (IS_MSB && is_top_word_i) ? PAD_LAST : 8'h00;

        // When the message ends on byte 127 both markers land in the same
        // byte and merge into 0x81.
        assign word_o[8*gi +: 8] = keep_byte | first_byte | last_byte;
    end

endmodule

// File: rtl/keccak_padder.sv
// -----------------------------------------------------------------------------
// keccak_padder
// Packs a byte-aligned message, delivered as 64-bit words, into 1024-bit rate
// blocks for an unbuffered Keccak core and applies pad10*1 to the final
// block. Each block is held on blk_* until the hasher takes it.
// Ports:
//   clk_i  : clock, all state changes on the rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : keccak_padder_if.slave (msg_* word stream in, blk_* block out)
// -----------------------------------------------------------------------------
module keccak_padder
    import keccak_padder_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_ni,
    keccak_padder_if.slave bus
);

    padder_state_t state_q;
    logic [3:0]    word_cnt_q;
    logic          pad_pending_q;
    logic          msg_ready_q;
    logic          blk_valid_q;
    logic          blk_last_q;

    logic [WORDS_PER_BLOCK-1:0][WORD_BITS-1:0] buf_flat;

    logic       fill_fire;
    logic       blk_fire;
    logic       load_pad;
    logic       clear_buf;
    logic [3:0] nb_eff;
    logic       pad_overflow;

    assign fill_fire = (state_q == FILL) && msg_ready_q && bus.msg_valid;
    assign blk_fire  = blk_valid_q && bus.blk_ready;
    assign load_pad  = blk_fire && (state_q == SEND) && pad_pending_q;
    assign clear_buf = blk_fire && !load_pad;

    // Non-final words are always full, whatever msg_nbytes says.
    assign nb_eff = bus.msg_last ? clamp_nbytes(bus.msg_nbytes) : 4'(WORD_BYTES);

    // A final word that exactly fills the block leaves no room for padding;
    // the padding then goes into a separate pad-only block.
    assign pad_overflow = (word_cnt_q == 4'(WORDS_PER_BLOCK - 1)) &&
                          (nb_eff == 4'(WORD_BYTES));

    // -------------------------------------------------------------------------
    // Word buffer: one register per block word. On a final-word transfer every
    // word from the current one upward is rewritten: the current word gets
    // the masked data, the word after it gets 0x01 when the current word was
    // full, and word 15 gets 0x80. Words above the current one are known to
    // be zero at that point, so padding them from zero is exact.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_word
        localparam logic [3:0]           IDX    = 4'(gi);
        localparam bit                   IS_TOP = (gi == WORDS_PER_BLOCK - 1);
        localparam logic [WORD_BITS-1:0] PAD_ONLY_WORD =
            (gi == 0) ? WORD_BITS'(PAD_FIRST) :
            IS_TOP    ? {PAD_LAST, {(WORD_BITS - 8){1'b0}}} :
                        '0;

        logic                 is_cur;
        logic                 is_next;
        logic                 is_tail;
        logic [WORD_BITS-1:0] pad_in;
        logic [3:0]           pad_nbytes;
        logic                 pad_top;
        logic [WORD_BITS-1:0] pad_out;
        logic [WORD_BITS-1:0] word_d;
        logic [WORD_BITS-1:0] word_q;

        assign is_cur  = (word_cnt_q == IDX);
        assign is_next = ({1'b0, word_cnt_q} + 5'd1) == {1'b0, IDX};
        assign is_tail = (IDX > word_cnt_q);

        assign pad_in     = is_cur ? bus.msg_data : '0;
        assign pad_nbytes = is_cur                                  ? nb_eff :
                            (is_next && nb_eff == 4'(WORD_BYTES))   ? 4'd0   :
                                                                      4'(WORD_BYTES);
        assign pad_top    = IS_TOP && bus.msg_last && !pad_overflow;

        keccak_pad_word u_pad_word (
            .word_i        (pad_in),
            .nbytes_i      (pad_nbytes),
            .is_top_word_i (pad_top),
            .word_o        (pad_out)
        );

        always_comb begin
            word_d = word_q;
            if (fill_fire) begin
                if (is_cur || (bus.msg_last && is_tail)) begin
                    word_d = pad_out;
                end
            end else if (load_pad) begin
                word_d = PAD_ONLY_WORD;
            end else if (clear_buf) begin
                word_d = '0;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                word_q <= '0;
            end else begin
                word_q <= word_d;
            end
        end

        assign buf_flat[gi] = word_q;
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered handshake outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= FILL;
            word_cnt_q    <= '0;
            pad_pending_q <= 1'b0;
            msg_ready_q   <= 1'b1;
            blk_valid_q   <= 1'b0;
            blk_last_q    <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (fill_fire) begin
                        if (bus.msg_last) begin
                            state_q       <= SEND;
                            msg_ready_q   <= 1'b0;
                            blk_valid_q   <= 1'b1;
                            blk_last_q    <= !pad_overflow;
                            pad_pending_q <= pad_overflow;
                        end else if (word_cnt_q == 4'(WORDS_PER_BLOCK - 1)) begin
                            state_q     <= SEND;
                            msg_ready_q <= 1'b0;
                            blk_valid_q <= 1'b1;
                            blk_last_q  <= 1'b0;
                        end else begin
                            word_cnt_q <= word_cnt_q + 4'd1;
                        end
                    end
                end

                SEND: begin
                    if (bus.blk_ready) begin
                        if (pad_pending_q) begin
                            state_q       <= SEND_PAD;
                            pad_pending_q <= 1'b0;
                            blk_last_q    <= 1'b1;
                        end else begin
                            state_q     <= FILL;
                            word_cnt_q  <= '0;
                            blk_last_q  <= 1'b0;
                            msg_ready_q <= 1'b1;
                            blk_valid_q <= 1'b0;
                        end
                    end
                end

                SEND_PAD: begin
                    if (bus.blk_ready) begin
                        state_q     <= FILL;
                        word_cnt_q  <= '0;
                        blk_last_q  <= 1'b0;
                        msg_ready_q <= 1'b1;
                        blk_valid_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

    assign bus.msg_ready = msg_ready_q;
    assign bus.blk_valid = blk_valid_q;
    assign bus.blk_last  = blk_last_q;
    assign bus.blk_data  = buf_flat;

endmodule

// File: doc/keccak_padder.md
Name: keccak_padder

Overview:
Message front end for keccak_unbuffered. It accepts a byte-aligned message as a stream of 64-bit words and packs the words into 1024-bit rate blocks. It applies Keccak pad10*1 padding to the final block. Each block is presented on the hasher's din/din_valid/ready interface and held stable until the hasher accepts it. This block does in hardware what the top-level bench does by hand when it builds a padded 1024-bit din.

Parameters:
RATE_BITS, 1024, Keccak rate and output block width; fixed by the hasher.
WORD_BITS, 64, input word width; RATE_BITS/WORD_BITS = 16 words per block.

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset
msg_data  input  64  message word; byte i = bits [8i+7:8i], and byte 0 is first in the message
msg_valid  input  1  msg_data/msg_last/msg_nbytes are valid
msg_last  input  1  current word is the final word of the message
msg_nbytes  input  4  valid bytes in the final word, 0..8; ignored (treated as 8) when msg_last=0
msg_ready  output  1  padder can take a word; word transfers when msg_valid && msg_ready
blk_data  output  1024  rate block to hasher din; word k = bits [64k+63:64k]
blk_valid  output  1  drives hasher din_valid
blk_last  output  1  block is the final (padded) block of the message
blk_ready  input  1  hasher ready; block transfers when blk_valid && blk_ready

Behaviour:
- Reset (reset=0, async): state=FILL, word_cnt=0, buffer=0, msg_ready=1, blk_valid=0, blk_last=0, blk_data=0.
- States: FILL, SEND, SEND_PAD.
- FILL:
  - msg_ready=1 and blk_valid=0.
  - On a transfer, write the word into buffer word word_cnt. Mask the bytes at index >= msg_nbytes to 0 when msg_last=1.
  - Non-last word with word_cnt=15: go to SEND with blk_last=0.
  - Non-last word with word_cnt<15: increment word_cnt.
  - Last word, block position p = 8*word_cnt + msg_nbytes:
    - p<128: byte[p] |= 0x01 and byte[127] |= 0x80. If p=127 the byte becomes 0x81. Go to SEND with blk_last=1.
    - p=128 (word_cnt=15, nbytes=8): go to SEND with blk_last=0 and set pad_pending.
- SEND:
  - msg_ready=0, blk_valid=1; blk_data and blk_last are held stable.
  - On blk_ready with pad_pending=1: load a pad-only block (byte0=0x01, byte127=0x80, rest 0), go to SEND_PAD, clear pad_pending.
  - On blk_ready otherwise: clear the buffer, word_cnt=0, blk_last=0, go to FILL.
- SEND_PAD: blk_valid=1, blk_last=1. On blk_ready: clear the buffer and go to FILL.
- Latency: blk_valid rises on the cycle after the completing word transfers. After block acceptance, msg_ready returns the next cycle.
- Throughput: 16 word cycles plus at least 1 send cycle per block. No overlap; the hasher is unbuffered.
- msg_nbytes>8 on a last word: clamp to 8.
- msg_valid=0 in FILL: no state change.
- Inputs are ignored while msg_ready=0.
- blk_ready held high continuously: each block transfers in exactly one cycle.
- Reset mid-block or mid-SEND: partial data is discarded; no block is emitted.
- Empty message (first word, last, nbytes=0): a single pad-only block with blk_last=1.

Decomposition:
- pkg_keccak adds:
  - RATE_BYTES=128 and WORDS_PER_BLOCK=16;
  - PAD_FIRST=8'h01 and PAD_LAST=8'h80;
  - padder_state_t enum {FILL, SEND, SEND_PAD}.
- One combinational sub-module, keccak_pad_word: it takes a word, nbytes and is_top_word, and returns the masked word with 0x01/0x80 ORed in.
- The word buffer, counter and FSM stay in keccak_padder.

Test Plan:
- Empty message (msg_last=1, nbytes=0, data=x) -> one block 1024'h80<…zeros…>01, blk_last=1.
- One word 64'h0000_0000_00AB_CDEF, last, nbytes=3 -> blk_data[63:0]=64'h0000_0000_01AB_CDEF, blk_data[1023:1016]=8'h80, all other bytes 0, blk_last=1.
- 127-byte message (15 full words + last with nbytes=7) -> byte 127 = 8'h81, single block, blk_last=1.
- 128-byte message (16 words, last nbytes=8) -> block 1 holds the raw data with blk_last=0. Block 2 is 80<…>01 with blk_last=1, and msg_ready=0 until block 2 is accepted.
- 2048-bit message then 1 byte, with blk_ready held low 5 cycles on each block -> blk_data is stable throughout, msg_ready=0, and exactly 3 blocks are emitted.
- reset driven low after 7 words -> all outputs return to reset values immediately. A subsequent 3-byte message yields the correct single block with no stale bytes.
